// File: rtl/alu_multicycle.sv
// alu_multicycle: MIPS-style ALU with single-cycle ops plus iterative
// shift-add multiply and restoring divide writing a HI/LO pair.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_SIZE-1:0] alu_op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               div_by_zero
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;
  int op;
  logic fire, last, neg_p, neg_q, neg_r;
  logic [SW-1:0] cnt, sh;
  logic [WIDTH-1:0] hi, lo, alu_res, mag1, mag2, mplier;
  logic [WIDTH-1:0] rem, quo, dvsr, rem_nx, quo_nx, q_fix, r_fix;
  logic [WIDTH:0] shl, diff;
  logic [2*WIDTH-1:0] prod, mcand, prod_nx, prod_fix;
  assign op       = int'(alu_op);
  assign in_ready = state == IDLE;
  assign fire     = in_valid && in_ready;
  assign last     = cnt == SW'(WIDTH - 1);
  assign sh       = in2[SW-1:0];
  assign mag1     = in1[WIDTH-1] ? -in1 : in1;
  assign mag2     = in2[WIDTH-1] ? -in2 : in2;
  assign prod_nx  = prod + (mplier[0] ? mcand : '0);
  assign prod_fix = neg_p ? -prod_nx : prod_nx;
  // Restoring step: a borrow out of the trial subtraction means keep the shifted remainder.
  assign shl      = {rem, quo[WIDTH-1]};
  assign diff     = shl - {1'b0, dvsr};
  assign rem_nx   = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx   = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign q_fix    = neg_q ? -quo_nx : quo_nx;
  assign r_fix    = neg_r ? -rem_nx : rem_nx;
  always_comb begin
    alu_res = '0;
    case (op)
      0:  alu_res = in1 + in2;
      1:  alu_res = in1 - in2;
      2:  alu_res = in1 & in2;
      3:  alu_res = in1 | in2;
      4:  alu_res = ~(in1 | in2);
      5:  alu_res = WIDTH'($signed(in1) < $signed(in2));
      6:  alu_res = WIDTH'(in1 < in2);
      7:  alu_res = in1 << sh;
      8:  alu_res = in1 >> sh;
      9:  alu_res = $signed(in1) >>> sh;
      10: alu_res = in2;
      14: alu_res = hi;
      15: alu_res = lo;
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = fire && (op == 11 || op == 12) ? MUL :
                           fire && op == 13 && in2 != '0 ? DIV : IDLE;
      MUL, DIV: state_nx = last ? DONE : state;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result <= '0;
      zero <= 1'b1;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      prod <= '0;
      mcand <= '0;
      mplier <= '0;
      rem <= '0;
      quo <= '0;
      dvsr <= '0;
      neg_p <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (fire) begin
        if (op == 11 || op == 12) begin
          mcand <= {{WIDTH{1'b0}}, op == 11 ? mag1 : in1};
          mplier <= op == 11 ? mag2 : in2;
          prod <= '0;
          neg_p <= op == 11 && (in1[WIDTH-1] ^ in2[WIDTH-1]);
          cnt <= '0;
        end else if (op == 13 && in2 != '0) begin
          rem <= '0;
          quo <= mag1;
          dvsr <= mag2;
          neg_q <= in1[WIDTH-1] ^ in2[WIDTH-1];
          neg_r <= in1[WIDTH-1];
          cnt <= '0;
        end else if (op == 13) begin
          hi <= in1;
          lo <= '1;
          result <= '1;
          zero <= 1'b0;
          div_by_zero <= 1'b1;
          out_valid <= 1'b1;
        end else begin
          result <= alu_res;
          zero <= alu_res == '0;
          div_by_zero <= 1'b0;
          out_valid <= 1'b1;
        end
      end else if (state == MUL) begin
        prod <= prod_nx;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (last) begin
          {hi, lo} <= prod_fix;
          result <= prod_fix[WIDTH-1:0];
          zero <= prod_fix[WIDTH-1:0] == '0;
          div_by_zero <= 1'b0;
          out_valid <= 1'b1;
        end
      end else if (state == DIV) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi <= r_fix;
          lo <= q_fix;
          result <= q_fix;
          zero <= q_fix == '0;
          div_by_zero <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vector table, reset-abort sequence and random
// ops checked against an arithmetic HI/LO reference model.
module tb_alu_multicycle;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic in_ready, out_valid, zero, div_by_zero;
  logic [3:0] alu_op = '0;
  logic [31:0] in1 = '0, in2 = '0, result;
  logic [31:0] m_hi = '0, m_lo = '0;
  int tests = 0, fails = 0;
  alu_multicycle #(.WIDTH(32), .OP_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .in1(in1), .in2(in2), .out_valid(out_valid),
    .result(result), .zero(zero), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  typedef struct {
    int op;
    logic [31:0] a, b, r;
    bit dz;
  } vec_t;
  vec_t vecs[19];
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Reference computed with 64-bit integer arithmetic.
  task automatic model(input int op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit dz);
    longint p, q, rm;
    logic [63:0] pu;
    dz = 0;
    r = '0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = ~(a | b);
      5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: r = (a < b) ? 32'd1 : 32'd0;
      7: r = a << b[4:0];
      8: r = a >> b[4:0];
      9: r = $signed(a) >>> b[4:0];
      10: r = b;
      11: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo;
      end
      12: begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32]; m_lo = pu[31:0]; r = m_lo;
      end
      13: begin
        if (b == 0) begin
          m_hi = a; m_lo = '1; dz = 1;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          rm = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0]; m_hi = rm[31:0];
        end
        r = m_lo;
      end
      14: r = m_hi;
      default: r = m_lo;
    endcase
  endtask
  task automatic run(string n, int op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] er, bit edz, bit poke);
    int lat = 1, low = 0;
    int elat = (op == 11 || op == 12 || (op == 13 && b != 0)) ? 33 : 1;
    chk({n, ".ready"}, 64'(in_ready), 1);
    in_valid = 1; alu_op = 4'(op); in1 = a; in2 = b;
    @(negedge clk);
    while (1) begin
      if (!in_ready) low++;
      if (out_valid || lat >= 60) break;
      in_valid = poke && lat == 3;
      alu_op = 0; in1 = 32'h11; in2 = 32'h22;
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    chk({n, ".lat"}, 64'(lat), 64'(elat));
    chk({n, ".busy"}, 64'(low), 64'(elat == 1 ? 0 : elat));
    chk({n, ".res"}, 64'(result), 64'(er));
    chk({n, ".zero"}, 64'(zero), 64'(er == 0));
    chk({n, ".dz"}, 64'(div_by_zero), 64'(edz));
    @(negedge clk);
    chk({n, ".hold"}, {31'd0, out_valid, result}, {32'd0, er});
  endtask
  initial begin
    logic [31:0] r, a, b;
    bit dz;
    int op, seen;
    vecs = '{
      '{0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0},
      '{1, 32'h5, 32'h5, 32'h0, 0},
      '{9, 32'h80000000, 32'h21, 32'hC0000000, 0},
      '{5, 32'hFFFFFFFF, 32'h1, 32'h1, 0},
      '{6, 32'hFFFFFFFF, 32'h1, 32'h0, 0},
      '{11, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 0},
      '{14, 32'h0, 32'h0, 32'hFFFFFFFF, 0},
      '{13, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 0},
      '{14, 32'h0, 32'h0, 32'hFFFFFFFF, 0},
      '{13, 32'h9, 32'h0, 32'hFFFFFFFF, 1},
      '{14, 32'h0, 32'h0, 32'h9, 0},
      '{13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0},
      '{14, 32'h0, 32'h0, 32'h0, 0},
      '{7, 32'h1, 32'h3F, 32'h80000000, 0},
      '{8, 32'h80000000, 32'h1F, 32'h1, 0},
      '{10, 32'hDEAD, 32'h1234, 32'h1234, 0},
      '{4, 32'h0, 32'h0, 32'hFFFFFFFF, 0},
      '{12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0},
      '{14, 32'h0, 32'h0, 32'hFFFFFFFE, 0}
    };
    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(in_ready), 1);
    chk("rst.outs", {32'd0, out_valid, zero, div_by_zero, 29'd0, result}, {32'd0, 3'b010, 29'd0, 32'd0});
    rst_n = 1;
    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b, r, dz);
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].dz, vecs[i].op == 11);
    end
    // Abort a MULTU with reset ten cycles in.
    in_valid = 1; alu_op = 12; in1 = 32'h12345; in2 = 32'h777;
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    #2;
    chk("abort.ready", 64'(in_ready), 1);
    chk("abort.outs", {32'd0, out_valid, zero, div_by_zero, 29'd0, result}, {32'd0, 3'b010, 29'd0, 32'd0});
    @(negedge clk);
    rst_n = 1;
    m_hi = 0; m_lo = 0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort.nopulse", 64'(seen), 0);
    run("abort.mflo", 15, 0, 0, 0, 0, 0);
    run("abort.mfhi", 14, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(1, 9);
        default: ;
      endcase
      model(op, a, b, r, dz);
      run($sformatf("rnd%0d_op%0d", i, op), op, a, b, r, dz, $urandom_range(0, 1) == 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, result, HI and LO width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter OP_SIZE, default 4, giving the width of alu_op.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: operation request.
REQ-006 Port in_ready, output, 1 bit: the block can accept a request.
REQ-007 Port alu_op, input, OP_SIZE bits: operation code.
REQ-008 Port in1, input, WIDTH bits: operand A.
REQ-009 Port in2, input, WIDTH bits: operand B.
REQ-010 Port out_valid, output, 1 bit: one-cycle pulse; result, zero and div_by_zero are valid.
REQ-011 Port result, output, WIDTH bits: operation result.
REQ-012 Port zero, output, 1 bit: result equals 0.
REQ-013 Port div_by_zero, output, 1 bit: the completed DIV had in2 equal to 0.

Function
REQ-014 The block SHALL accept a request on a cycle where in_valid and in_ready are both 1; operands and op SHALL be captured on that edge.
REQ-015 The op encoding SHALL be:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR
- 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA
- 10 LUI (result = in2), 11 MULT (signed), 12 MULTU, 13 DIV (signed)
- 14 MFHI, 15 MFLO
REQ-016 ADD and SUB SHALL wrap modulo 2^WIDTH; SLT and SLTU SHALL return 1 or 0, zero-extended.
REQ-017 Shifts SHALL shift in1 by the amount in2[$clog2(WIDTH)-1:0]; higher bits of in2 SHALL be ignored.
REQ-018 Ops 0-10, 14 and 15 are single-cycle: out_valid = 1 on the cycle after acceptance; in_ready SHALL remain 1.
REQ-019 The FSM SHALL have states IDLE, MUL, DIV and DONE.
- IDLE -> MUL on accepted op 11/12.
- IDLE -> DIV on accepted op 13 with in2 != 0.
- MUL/DIV -> DONE after exactly WIDTH iteration cycles.
- DONE -> IDLE unconditionally.
REQ-020 in_ready SHALL be 0 in MUL, DIV and DONE; requests presented there SHALL be ignored, not queued.
REQ-021 MULT/MULTU SHALL compute the full 2*WIDTH-bit product by one shift-add step per cycle: HI = upper half, LO = lower half.
- MULT: operand magnitudes are iterated; the sign is applied in DONE.
REQ-022 DIV SHALL use one restoring step per cycle: LO = quotient truncated toward zero; HI = remainder carrying the sign of in1.
REQ-023 Multi-cycle op completion: out_valid = 1 in the DONE cycle, WIDTH+1 cycles after acceptance; result = new LO.
REQ-024 DIV with in2 = 0: no iteration; on the next cycle LO = all ones, HI = in1, out_valid = 1, div_by_zero = 1, FSM remains IDLE.
REQ-025 DIV with in1 = most negative value and in2 = -1: LO = in1, HI = 0, no error flag.
REQ-026 MFHI/MFLO SHALL return the HI/LO value from the last completed multiply or divide.
REQ-027 zero SHALL equal (result == 0) whenever out_valid = 1; div_by_zero SHALL be 0 except as in REQ-024.
REQ-028 result, zero and div_by_zero SHALL hold their values between out_valid pulses.

Reset
REQ-029 While rst_n = 0, the block SHALL force:
- state = IDLE
- in_ready = 1
- out_valid = 0, result = 0, zero = 1, div_by_zero = 0
- HI = 0, LO = 0
REQ-030 Reset asserted mid-MUL/DIV SHALL abort the operation with no out_valid pulse; HI/LO SHALL read 0 afterwards.
REQ-031 The first request SHALL be accepted on the first rising edge at which rst_n = 1 and in_valid = 1.

Verification (WIDTH = 32)
REQ-032 ADD 0x7FFFFFFF + 1 -> next cycle out_valid = 1, result = 0x80000000, zero = 0; SUB 5 - 5 -> result = 0, zero = 1.
REQ-033 SRA 0x80000000 by in2 = 0x21 -> result = 0xC0000000 (shift amount 1); SLT -1 < 1 -> 1; SLTU on the same operands -> 0.
REQ-034 MULT -3 * 7 -> in_ready low for 33 cycles, out_valid 33 cycles after acceptance, result = 0xFFFFFFEB; then MFHI -> 0xFFFFFFFF; a request presented while busy is ignored.
REQ-035 DIV -7 / 2 -> LO = -3, HI = -1; DIV 9 / 0 -> next cycle div_by_zero = 1, result = 0xFFFFFFFF; then MFHI -> 9.
REQ-036 MULTU started, rst_n pulsed low at cycle 10 -> no out_valid, in_ready = 1 immediately; then MFLO -> 0, zero = 1.
